// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store access controller: turns a pipeline request into a word-aligned,
// byte-enabled memory transaction, stalls until ack or timeout, then reports one response.
module mem_access_ctrl #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [1:0]  req_size,
   input  logic        req_bitExt,
   output logic        req_ready,
   output logic        stall,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_data,
   output logic [1:0]  rsp_offset,
   output logic [1:0]  rsp_size,
   output logic        rsp_bitExt,
   output logic        rsp_write,
   output logic        fault,
   output logic [31:0] fault_addr
);

   localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   addr_q, wdata_q, rdata_q, fault_addr_q;
   logic [3:0]    be_q;
   logic [1:0]    size_q;
   logic          bitext_q, write_q, fault_q;

   logic          legal;
   logic [3:0]    be_calc;
   logic [31:0]   wdata_calc;
   logic          timeout_hit;

   assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      legal      = 1'b0;
      be_calc    = 4'b0000;
      wdata_calc = req_wdata;
      case (req_size)
         2'd0: begin
            legal   = (req_addr[1:0] == 2'b00);
            be_calc = 4'b1111;
         end
         2'd1: begin
            legal      = ~req_addr[0];
            be_calc    = req_addr[1] ? 4'b0011 : 4'b1100;
            wdata_calc = {2{req_wdata[15:0]}};
         end
         2'd2: begin
            legal      = 1'b1;
            be_calc    = 4'b1000 >> req_addr[1:0];
            wdata_calc = {4{req_wdata[7:0]}};
         end
         default: ;
      endcase
   end

   // NOTE: reset is synchronous, so it only takes effect at a rising edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (req_valid) state_d = legal ? ACCESS : RESP;
         end
         ACCESS: begin
            if (mem_ack || timeout_hit) state_d = RESP;
            else                        cnt_d   = cnt_q + CW'(1);
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req_ready = 1'b0;
      stall     = 1'b0;
      mem_req   = 1'b0;
      rsp_valid = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            stall     = req_valid;
         end
         ACCESS: begin
            stall   = 1'b1;
            mem_req = 1'b1;
         end
         RESP:    rsp_valid = 1'b1;
         default: ;
      endcase
      mem_we = mem_req & write_q;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         addr_q       <= '0;
         wdata_q      <= '0;
         be_q         <= '0;
         size_q       <= '0;
         bitext_q     <= 1'b0;
         write_q      <= 1'b0;
         rdata_q      <= '0;
         fault_q      <= 1'b0;
         fault_addr_q <= '0;
      end else begin
         case (state_q)
            IDLE: if (req_valid) begin
               addr_q   <= req_addr;
               wdata_q  <= wdata_calc;
               be_q     <= be_calc;
               size_q   <= req_size;
               bitext_q <= req_bitExt;
               write_q  <= req_write;
               rdata_q  <= '0;
               fault_q  <= ~legal;
               if (!legal) fault_addr_q <= req_addr;
            end
            ACCESS: begin
               // Ack takes priority over a timeout expiring in the same cycle.
               if (mem_ack) begin
                  rdata_q <= write_q ? 32'h0 : mem_rdata;
                  fault_q <= 1'b0;
               end else if (timeout_hit) begin
                  rdata_q      <= '0;
                  fault_q      <= 1'b1;
                  fault_addr_q <= addr_q;
               end
            end
            default: ;
         endcase
      end
   end

   assign mem_addr   = {addr_q[31:2], 2'b00};
   assign mem_wdata  = wdata_q;
   assign mem_be     = be_q;
   assign rsp_data   = rdata_q;
   assign rsp_offset = addr_q[1:0];
   assign rsp_size   = size_q;
   assign rsp_bitExt = bitext_q;
   assign rsp_write  = write_q;
   assign fault      = fault_q;
   assign fault_addr = fault_addr_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed cases plus random transactions
// checked cycle by cycle against a transaction-level model of the access rules.
module tb_mem_access_ctrl;

   localparam int T = 6;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_write, req_bitExt;
   logic [31:0] req_addr, req_wdata;
   logic [1:0]  req_size;
   logic        req_ready, stall, mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        rsp_valid, rsp_bitExt, rsp_write, fault;
   logic [31:0] rsp_data, fault_addr;
   logic [1:0]  rsp_offset, rsp_size;

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] exp_fault_addr;

   always #5 clk = ~clk;

   mem_access_ctrl #(.TIMEOUT(T)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_size(req_size), .req_bitExt(req_bitExt),
      .req_ready(req_ready), .stall(stall),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_be(mem_be),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_offset(rsp_offset),
      .rsp_size(rsp_size), .rsp_bitExt(rsp_bitExt), .rsp_write(rsp_write),
      .fault(fault), .fault_addr(fault_addr)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   // Inputs change 1 ns after the rising edge; outputs are sampled at the falling edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #4;
   endtask

   task automatic scramble_req();
      req_write  = 1'($urandom);
      req_addr   = $urandom;
      req_wdata  = $urandom;
      req_size   = 2'($urandom);
      req_bitExt = 1'($urandom);
   endtask

   task automatic gap(input int n);
      for (int i = 0; i < n; i++) begin
         req_valid = 1'b0;
         scramble_req();
         mem_ack   = 1'($urandom);
         mem_rdata = $urandom;
         settle();
         check("gap_rsp_valid", rsp_valid, 1'b0);
         check("gap_req_ready", req_ready, 1'b1);
         check("gap_stall", stall, 1'b0);
         check("gap_mem_req", mem_req, 1'b0);
         tick();
      end
      mem_ack = 1'b0;
   endtask

   // One full transaction from the request cycle through the response cycle.
   // delay = number of ACCESS cycles before the ack; delay >= T means no ack in time.
   task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic bext, input int delay,
                         input logic [31:0] rdata);
      logic [1:0]  off;
      logic        legal, exp_fault;
      logic [3:0]  exp_be;
      logic [31:0] exp_wdata, exp_data;
      off = addr[1:0];
      case (size)
         2'd0:    legal = (off == 2'd0);
         2'd1:    legal = (off[0] == 1'b0);
         2'd2:    legal = 1'b1;
         default: legal = 1'b0;
      endcase
      case (size)
         2'd0:    exp_be = 4'hF;
         2'd1:    exp_be = (off == 2'd0) ? 4'hC : 4'h3;
         default: exp_be = 4'(1 << (3 - int'(off)));
      endcase
      case (size)
         2'd1:    exp_wdata = {16'h0, wdata[15:0]} * 32'h0001_0001;
         2'd2:    exp_wdata = {24'h0, wdata[7:0]} * 32'h0101_0101;
         default: exp_wdata = wdata;
      endcase
      exp_fault = !legal || (delay >= T);
      exp_data  = (exp_fault || wr) ? 32'h0 : rdata;

      req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
      req_size = size; req_bitExt = bext;
      mem_ack = 1'($urandom); mem_rdata = $urandom;
      settle();
      check("req_ready", req_ready, 1'b1);
      check("req_stall", stall, 1'b1);
      check("req_mem_req", mem_req, 1'b0);
      check("req_rsp_valid", rsp_valid, 1'b0);
      tick();
      req_valid = 1'b0;
      scramble_req();

      if (legal) begin
         for (int i = 0; i < T; i++) begin
            mem_ack   = (i == delay);
            mem_rdata = (i == delay) ? rdata : $urandom;
            settle();
            check("acc_mem_req", mem_req, 1'b1);
            check("acc_mem_we", mem_we, wr);
            check("acc_mem_addr", mem_addr, {addr[31:2], 2'b00});
            check("acc_mem_be", mem_be, exp_be);
            if (wr) check("acc_mem_wdata", mem_wdata, exp_wdata);
            check("acc_stall", stall, 1'b1);
            check("acc_req_ready", req_ready, 1'b0);
            check("acc_rsp_valid", rsp_valid, 1'b0);
            tick();
            if (i == delay) break;
         end
      end

      mem_ack = 1'($urandom); mem_rdata = $urandom;
      settle();
      if (exp_fault) exp_fault_addr = addr;
      check("rsp_valid", rsp_valid, 1'b1);
      check("rsp_fault", fault, exp_fault);
      check("rsp_data", rsp_data, exp_data);
      check("rsp_offset", rsp_offset, off);
      check("rsp_size", rsp_size, size);
      check("rsp_bitExt", rsp_bitExt, bext);
      check("rsp_write", rsp_write, wr);
      check("rsp_fault_addr", fault_addr, exp_fault_addr);
      check("rsp_mem_req", mem_req, 1'b0);
      check("rsp_stall", stall, 1'b0);
      check("rsp_req_ready", req_ready, 1'b0);
      tick();
      mem_ack = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
      scramble_req();
      exp_fault_addr = '0;
      repeat (3) tick();
      settle();
      check("rst_mem_req", mem_req, 1'b0);
      check("rst_mem_we", mem_we, 1'b0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_mem_wdata", mem_wdata, 32'h0);
      check("rst_mem_be", mem_be, 4'h0);
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_rsp_data", rsp_data, 32'h0);
      check("rst_rsp_fields", {rsp_offset, rsp_size, rsp_bitExt, rsp_write}, 6'h0);
      check("rst_fault", fault, 1'b0);
      check("rst_fault_addr", fault_addr, 32'h0);
      check("rst_req_ready", req_ready, 1'b1);
      check("rst_stall", stall, 1'b0);
      rst_n = 1'b1;
      tick();

      do_txn(1'b0, 32'h0000_1003, 32'h0, 2'd2, 1'b1, 0, 32'h1122_3344);
      gap(1);
      do_txn(1'b1, 32'h0000_2002, 32'hDEAD_BEEF, 2'd1, 1'b0, 5, 32'h0);
      gap(1);
      do_txn(1'b0, 32'h0000_3001, 32'h0, 2'd0, 1'b0, 0, 32'h0);
      gap(1);
      do_txn(1'b0, 32'h0000_5000, 32'h0, 2'd0, 1'b0, T, 32'hCAFE_F00D);
      do_txn(1'b0, 32'h0000_5004, 32'h0, 2'd0, 1'b0, T - 1, 32'hCAFE_F00D);
      do_txn(1'b0, 32'h0000_6000, 32'h0, 2'd0, 1'b0, 0, 32'hA5A5_0001);
      do_txn(1'b0, 32'h0000_6006, 32'h0, 2'd1, 1'b1, 0, 32'h5A5A_0002);

      // Reset in the middle of an access, then a late ack that must be ignored.
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_4000; req_size = 2'd0;
      tick();
      req_valid = 1'b0;
      settle();
      check("mid_mem_req", mem_req, 1'b1);
      tick();
      settle();
      rst_n = 1'b0;
      tick();
      settle();
      exp_fault_addr = '0;
      check("midrst_mem_req", mem_req, 1'b0);
      check("midrst_mem_addr", mem_addr, 32'h0);
      check("midrst_req_ready", req_ready, 1'b1);
      rst_n = 1'b1;
      mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
      tick();
      mem_ack = 1'b0;
      settle();
      check("late_ack_rsp_valid", rsp_valid, 1'b0);
      check("late_ack_mem_req", mem_req, 1'b0);
      tick();
      settle();
      check("late_ack_rsp_valid2", rsp_valid, 1'b0);
      check("late_ack_rsp_data", rsp_data, 32'h0);
      check("late_ack_fault_addr", fault_addr, 32'h0);
      tick();

      for (int k = 0; k < 200; k++) begin
         do_txn(1'($urandom), $urandom, $urandom, 2'($urandom), 1'($urandom),
                $urandom_range(0, T + 1), $urandom);
         gap($urandom_range(0, 2));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Load/store access controller in the MEM stage, directly upstream of the load-data decoder. It converts a pipeline load/store request into a word-aligned, byte-enabled transaction on the data-memory port, and stalls the pipeline until the memory acknowledges. It then presents the raw read word with the registered offset, size and extension controls that the decoder consumes. Byte order is big-endian: byte offset 0 is bits [31:24].

## Interface
- TIMEOUT, 255: maximum ACCESS cycles without `mem_ack` before a bus fault; must be ≥1.

- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  pipeline load/store request present.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- req_size  in  2  0 word, 1 half, 2 byte, 3 illegal.
- req_bitExt  in  1  0 sign extend, 1 zero extend (loads only).
- req_ready  out  1  high only in IDLE.
- stall  out  1  pipeline hold.
- mem_req  out  1  memory request, held until acked.
- mem_we  out  1  write strobe qualifier.
- mem_addr  out  32  word address, bits [1:0] always 0.
- mem_wdata  out  32  lane-replicated store data.
- mem_be  out  4  byte enables; be[3] = bits [31:24].
- mem_ack  in  1  memory completion, one cycle.
- mem_rdata  in  32  read word, valid with `mem_ack`.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_data  out  32  raw read word (0 for stores and faults).
- rsp_offset  out  2  latched `req_addr[1:0]`.
- rsp_size  out  2  latched `req_size`.
- rsp_bitExt  out  1  latched `req_bitExt`.
- rsp_write  out  1  latched `req_write`.
- fault  out  1  valid with `rsp_valid`: misaligned/illegal size, or timeout.
- fault_addr  out  32  latched `req_addr` on fault, else holds its previous value.

## Operation
- States: IDLE, ACCESS, RESP.
- **IDLE**
  - An aligned request (`req_valid` high and legal) latches the address, size, bitExt, write and data, then goes to ACCESS.
  - A misaligned request goes to RESP with a pending fault and no memory access.
- **Legality**
  - Word requires offset 0.
  - Half requires offset 0 or 2.
  - Byte accepts any offset.
  - Size 3 is always illegal.
- **ACCESS**
  - `mem_req` is high, and addr/we/wdata/be are stable throughout.
  - When `mem_ack` is high: capture `mem_rdata` (loads only; stores capture 0), go to RESP with no fault.
  - Timeout counter: cleared on ACCESS entry, increments each ACCESS cycle without ack. When it reaches TIMEOUT, go to RESP with fault; `mem_req` drops.
  - If ack and timeout occur in the same cycle, ack wins.
- **RESP**
  - `rsp_valid` is high for exactly one cycle, then the block returns to IDLE.
- **Byte enables**
  - Byte: 4'b1000 >> offset.
  - Half: offset 0 gives 4'b1100, offset 2 gives 4'b0011.
  - Word: 4'b1111.
  - Loads drive the same BE as stores.
- **Store data**
  - Byte: {4{wdata[7:0]}}.
  - Half: {2{wdata[15:0]}}.
  - Word: unchanged.
- **stall** = (IDLE and `req_valid`) or ACCESS. It is low in RESP, so the pipeline advances on the `rsp_valid` cycle.
- `mem_ack` outside ACCESS is ignored.
- **Reset**
  - Mid-operation reset forces IDLE at the next edge.
  - `mem_req` drops; a later `mem_ack` is ignored.
  - All registered outputs return to 0.

## Timing
- Reset values:
  - `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_be`: 0.
  - `rsp_*`, `fault`, `fault_addr`: 0.
  - `req_ready`: 1.
  - `stall`: 0 (with `req_valid` low).
- Request accepted at edge N: `mem_req` is high from cycle N+1.
- Ack sampled at edge M: `rsp_valid` is high in cycle M+1.
- Minimum load latency, acceptance to `rsp_valid`, is 2 cycles (ack in the first ACCESS cycle).
- Misaligned request: `rsp_valid` with `fault` in the cycle after acceptance; `mem_req` never asserts.
- Timeout: with no ack, `rsp_valid` with `fault` occurs TIMEOUT+1 cycles after acceptance.
- `req_ready`, `stall`, `mem_*` are combinational from state or registered; there is no combinational path from `mem_ack` to `mem_req`.
- A new request can be accepted in the cycle after RESP.

## Test plan
- **Load byte, offset 3, zero extend.** `req_addr`=0x1003, size 2, bitExt 1; ack in cycle 1 with `mem_rdata`=0x11223344.
  - `mem_addr`=0x1000, `mem_be`=4'b0001.
  - Next cycle: `rsp_valid`, `rsp_data`=0x11223344, `rsp_offset`=3, `rsp_size`=2, `rsp_bitExt`=1, `fault`=0.
- **Store half, offset 2.** `req_addr`=0x2002, `req_wdata`=0xDEADBEEF; ack after 5 wait cycles.
  - `mem_we`=1, `mem_be`=4'b0011, `mem_wdata`=0xBEEFBEEF, stable for all 6 ACCESS cycles.
  - `stall` is high until RESP.
- **Misaligned word.** `req_addr`=0x3001, size 0.
  - No `mem_req`.
  - Next cycle: `rsp_valid`, `fault`=1, `fault_addr`=0x3001.
- **Timeout.** TIMEOUT=4, `mem_ack` held low.
  - `mem_req` is high 4 cycles.
  - Then `rsp_valid`, `fault`=1, `rsp_data`=0.
  - Repeat with ack coinciding with the 4th cycle: no fault.
- **Reset mid-ACCESS.** `rst_n` low for 1 cycle.
  - `mem_req` is 0 at the next edge.
  - A late `mem_ack` produces no `rsp_valid`.
- **Back-to-back loads.** Two loads with single-cycle acks.
  - Second acceptance in the cycle after the first RESP.
  - Exactly two `rsp_valid` pulses with correct latched fields.
